cam_cfg_sequencer: RTL and testbench

- Sits directly downstream of the camera configuration ROM and upstream of the SCCB write master.
- On a start pulse, walks ROM addresses from 0 and decodes each 16-bit entry as {reg[15:8], value[7:0]}.
- Issues one SCCB write per entry and honours in-band control codes: 16'hFF_F0 means delay, 16'hFF_FF means end.
- Asserts o_done when the sequence finishes; the camera capture path is gated on o_done.

---
 rtl/cam_cfg_pkg.sv | 30 +++
 rtl/cam_cfg_delay_cnt.sv | 38 +++
 rtl/cam_cfg_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera configuration sequencer.
// The ROM holds {reg, value} pairs; two reserved words act as in-band controls.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_REQ    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DELAY  = 3'd5,
        ST_DONE   = 3'd6
    } cfg_state_e;

    localparam logic [15:0] CFG_DELAY_CODE = 16'hFF_F0;
    localparam logic [15:0] CFG_END_CODE   = 16'hFF_FF;

    localparam int CFG_CLK_HZ_DEFAULT   = 25_000_000;
    localparam int CFG_DELAY_US_DEFAULT = 1000;

    // Stall length in clock cycles; never less than one so the counter load stays valid.
    function automatic int cfg_delay_cycles(input int clk_hz, input int delay_us);
        int cycles;
        cycles = (clk_hz / 1_000_000) * delay_us;
        return (cycles < 1) ? 1 : cycles;
    endfunction

    localparam int DELAY_CYCLES = cfg_delay_cycles(CFG_CLK_HZ_DEFAULT, CFG_DELAY_US_DEFAULT);

endpackage

// File: rtl/cam_cfg_delay_cnt.sv
// Load/decrement down-counter with a zero flag, used to time delay entries.
// Holds at zero; a load always takes priority over a decrement.
module cam_cfg_delay_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise step down until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Camera configuration sequencer: walks the config ROM from address 0 and
// turns each {reg, value} entry into one SCCB write, honouring delay and end
// codes. Optional macro CAM_CFG_RETRY_EN re-issues a NACKed write up to
// MAX_RETRY times before flagging an error and moving on.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int CLK_HZ    = CFG_CLK_HZ_DEFAULT,
    parameter int DELAY_US  = CFG_DELAY_US_DEFAULT,
    parameter int ADDR_W    = 7,
    parameter int MAX_RETRY = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_valid,
    input  logic              i_sccb_ready,
    output logic [7:0]        o_sccb_reg,
    output logic [7:0]        o_sccb_val,
    input  logic              i_sccb_done,
    input  logic              i_sccb_nack,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int                CYCLES    = cfg_delay_cycles(CLK_HZ, DELAY_US);
    localparam int                CNT_W     = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // The retry counter is two bits wide, so the limit has to fit in it.
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_max_retry_range
        $error("MAX_RETRY must be in 0..3");
    end

    cfg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        val_q, val_d;
    logic              err_q, err_d;
    logic              advance;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

`ifdef CAM_CFG_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    logic [1:0] retry_q, retry_d;
`endif

    cam_cfg_delay_cnt #(
        .WIDTH(CNT_W)
    ) u_delay_cnt (
        .clk     (i_clk),
        .rst     (i_rst),
        .load    (cnt_load),
        .load_val(CNT_LOAD),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    // State and datapath registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
`ifdef CAM_CFG_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            err_q   <= err_d;
`ifdef CAM_CFG_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // Next-state logic; "advance" moves to the next entry, stopping at the last address.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        reg_d    = reg_q;
        val_d    = val_q;
        err_d    = err_q;
        advance  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef CAM_CFG_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    addr_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (i_rom_data == CFG_END_CODE) begin
                    state_d = ST_DONE;
                end else if (i_rom_data == CFG_DELAY_CODE) begin
                    cnt_load = 1'b1;
                    state_d  = ST_DELAY;
                end else begin
                    reg_d   = i_rom_data[15:8];
                    val_d   = i_rom_data[7:0];
`ifdef CAM_CFG_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_sccb_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_sccb_done) begin
`ifdef CAM_CFG_RETRY_EN
                    if (i_sccb_nack && (retry_q < RETRY_LIMIT)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        if (i_sccb_nack) begin
                            err_d = 1'b1;
                        end
                        advance = 1'b1;
                    end
`else
                    if (i_sccb_nack) begin
                        err_d = 1'b1;
                    end
                    advance = 1'b1;
`endif
                end
            end
            ST_DELAY: begin
                if (cnt_zero) begin
                    advance = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_sccb_valid = (state_q == ST_REQ);
        o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        o_done       = (state_q == ST_DONE);
        o_err        = err_q;
        o_rom_addr   = addr_q;
        o_sccb_reg   = reg_q;
        o_sccb_val   = val_q;
    end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Self-checking bench for cam_cfg_sequencer. Expected writes come from a
// ROM-walking reference model and are checked by a scoreboard monitor.
// Honours CAM_CFG_RETRY_EN for the expected retry behaviour.
module tb_cam_cfg_sequencer;

    localparam int CLK_HZ    = 1_000_000;
    localparam int DELAY_US  = 10;
    localparam int DLY       = 10;
    localparam int ADDR_W    = 7;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [6:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic        o_sccb_valid;
    logic        i_sccb_ready;
    logic [7:0]  o_sccb_reg;
    logic [7:0]  o_sccb_val;
    logic        i_sccb_done;
    logic        i_sccb_nack;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    cam_cfg_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .DELAY_US (DELAY_US),
        .ADDR_W   (ADDR_W),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_sccb_valid(o_sccb_valid),
        .i_sccb_ready(i_sccb_ready),
        .o_sccb_reg  (o_sccb_reg),
        .o_sccb_val  (o_sccb_val),
        .i_sccb_done (i_sccb_done),
        .i_sccb_nack (i_sccb_nack),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] rom [128];
    logic [15:0] exp_q [$];
    int          exp_acc;
    logic        exp_err;

    int nack_addr  = -1;
    int nack_count = 0;
    int nack_given = 0;
    int ready_mode = 1;
    int fixed_lat  = 1;
    int bp_armed   = 0;

    int acc_count    = 0;
    int stall_cycles = 0;
    int dwell_addr   = -1;
    int dwell_cnt    = 0;
    int wrapped      = 0;

    // Compare one observed value against the model's value.
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference model: walk the ROM by its rules and list every accepted write.
    task automatic applyStimulus_model();
        int nacks;
        int attempts;
        exp_q.delete();
        exp_err = 1'b0;
        for (int a = 0; a < 128; a++) begin
            if (rom[a] == 16'hFFFF) break;
            if (rom[a] != 16'hFFF0) begin
                nacks = (a == nack_addr) ? nack_count : 0;
`ifdef CAM_CFG_RETRY_EN
                attempts = (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
                if (nacks > MAX_RETRY) exp_err = 1'b1;
`else
                attempts = 1;
                if (nacks > 0) exp_err = 1'b1;
`endif
                for (int k = 0; k < attempts; k++) exp_q.push_back(rom[a]);
            end
            if (a == 127) exp_err = 1'b1;
        end
        exp_acc = exp_q.size();
    endtask

    // Pulse start, then check restart address, completion, error flag and write count.
    task automatic applyStimulus(input string name);
        int base;
        int budget;
        applyStimulus_model();
        base = acc_count;
        i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        checkOutput({name, "_start_addr"}, int'(o_rom_addr), 0);
        checkOutput({name, "_start_busy"}, int'(o_busy), 1);
        budget = 0;
        while (!o_done && budget < 20000) begin
            @(posedge clk); #2;
            budget++;
        end
        checkOutput({name, "_done"}, int'(o_done), 1);
        checkOutput({name, "_busy_low"}, int'(o_busy), 0);
        checkOutput({name, "_err"}, int'(o_err), int'(exp_err));
        checkOutput({name, "_writes"}, acc_count - base, exp_acc);
        checkOutput({name, "_left_in_sb"}, exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each accept and checks hold-stability under backpressure.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_reg   = '0;
        logic [7:0] prev_val   = '0;
        logic       prev_busy  = 1'b0;
        logic [6:0] prev_addr  = '0;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("hold_valid", int'(o_sccb_valid), 1);
                    checkOutput("hold_reg", int'(o_sccb_reg), int'(prev_reg));
                    checkOutput("hold_val", int'(o_sccb_val), int'(prev_val));
                end
                prev_stall = o_sccb_valid && !i_sccb_ready;
                prev_reg   = o_sccb_reg;
                prev_val   = o_sccb_val;
                if (prev_stall) stall_cycles++;
                if (o_sccb_valid && i_sccb_ready) begin
                    acc_count++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("write_reg", int'(o_sccb_reg), int'(e[15:8]));
                        checkOutput("write_val", int'(o_sccb_val), int'(e[7:0]));
                    end
                end
                if (o_busy && int'(o_rom_addr) == dwell_addr) dwell_cnt++;
                if (prev_busy && o_busy && prev_addr != 7'd0 && o_rom_addr == 7'd0) wrapped = 1;
                prev_busy = o_busy;
                prev_addr = o_rom_addr;
            end
        end
    end

    // ROM with one cycle of latency plus an SCCB master model with random or forced ready.
    initial begin
        int          seen_acc  = 0;
        int          pending   = 0;
        int          timer     = 0;
        logic        pend_nack = 1'b0;
        int          bp_left   = 0;
        logic [6:0]  addr_prev = '0;
        i_sccb_ready = 1'b0;
        i_sccb_done  = 1'b0;
        i_sccb_nack  = 1'b0;
        i_rom_data   = '0;
        forever begin
            @(posedge clk); #1;
            i_rom_data  = rom[addr_prev];
            addr_prev   = o_rom_addr;
            i_sccb_done = 1'b0;
            i_sccb_nack = 1'b0;
            if (i_rst) begin
                pending  = 0;
                seen_acc = acc_count;
            end else if (acc_count != seen_acc) begin
                seen_acc  = acc_count;
                pending   = 1;
                timer     = fixed_lat ? 4 : int'($urandom_range(1, 6));
                pend_nack = (int'(o_rom_addr) == nack_addr) && (nack_given < nack_count);
                if (pend_nack) nack_given++;
            end else if (pending != 0) begin
                timer--;
                if (timer == 0) begin
                    i_sccb_done = 1'b1;
                    i_sccb_nack = pend_nack;
                    pending     = 0;
                end
            end
            if (ready_mode == 0) begin
                i_sccb_ready = ($urandom_range(0, 3) != 0);
            end else if (ready_mode == 2) begin
                if (bp_armed != 0 && o_sccb_valid) begin
                    bp_armed = 0;
                    bp_left  = 7;
                end
                i_sccb_ready = (bp_left == 0);
                if (bp_left > 0) bp_left--;
            end else begin
                i_sccb_ready = 1'b1;
            end
        end
    end

    // Fill the ROM with the basic {write, delay, write, end} program.
    task automatic load_basic_rom();
        for (int a = 0; a < 128; a++) rom[a] = 16'h1100;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    // Main sequence of scenarios.
    initial begin
        int len;
        int budget;
        int base;
        i_rst   = 1'b1;
        i_start = 1'b0;
        load_basic_rom();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_done", int'(o_done), 0);
        checkOutput("rst_err", int'(o_err), 0);
        checkOutput("rst_valid", int'(o_sccb_valid), 0);
        checkOutput("rst_addr", int'(o_rom_addr), 0);
        i_rst = 1'b0;
        @(posedge clk); #2;

        $display("[TB] basic program with delay");
        ready_mode = 1; fixed_lat = 1; dwell_addr = 1; dwell_cnt = 0;
        applyStimulus("basic");
        checkOutput("delay_dwell", dwell_cnt, DLY + 2);
        dwell_addr = -1;

        $display("[TB] backpressure");
        ready_mode = 2; bp_armed = 1; stall_cycles = 0;
        applyStimulus("bp");
        checkOutput("bp_stall_cycles", stall_cycles, 7);

        $display("[TB] nack on second write");
        ready_mode = 1; nack_addr = 2; nack_count = 1; nack_given = 0;
        applyStimulus("nack_once");
        nack_count = 99; nack_given = 0;
        applyStimulus("nack_always");
        nack_addr = -1; nack_count = 0;

        $display("[TB] rom without end marker");
        for (int a = 0; a < 128; a++) rom[a] = 16'h1100;
        ready_mode = 0; fixed_lat = 0; wrapped = 0;
        applyStimulus("no_end");
        checkOutput("no_wrap", wrapped, 0);
        checkOutput("no_end_last_addr", int'(o_rom_addr), 127);

        $display("[TB] random programs");
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 128; a++) rom[a] = 16'h1100;
            len = int'($urandom_range(1, 20));
            for (int a = 0; a < len; a++) begin
                if ($urandom_range(0, 5) == 0) rom[a] = 16'hFFF0;
                else rom[a] = {8'($urandom_range(0, 254)), 8'($urandom)};
            end
            rom[len]   = 16'hFFFF;
            nack_addr  = int'($urandom_range(0, len));
            nack_count = int'($urandom_range(0, 5));
            nack_given = 0;
            applyStimulus("random");
        end
        nack_addr = -1; nack_count = 0;

        $display("[TB] reset during WAIT");
        load_basic_rom();
        ready_mode = 1; fixed_lat = 1;
        applyStimulus_model();
        base = acc_count;
        i_start = 1'b1;
        @(posedge clk); #2;
        i_start = 1'b0;
        budget = 0;
        while (acc_count < base + 2 && budget < 2000) begin
            @(posedge clk); #2;
            budget++;
        end
        checkOutput("rst_wait_reached", acc_count - base, 2);
        i_rst = 1'b1;
        @(posedge clk); #2;
        checkOutput("midrst_busy", int'(o_busy), 0);
        checkOutput("midrst_valid", int'(o_sccb_valid), 0);
        checkOutput("midrst_done", int'(o_done), 0);
        i_rst = 1'b0;
        @(posedge clk); #2;
        applyStimulus("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
